// File: rtl/wb_if.sv
// Pipelined Wishbone bus bundle shared by the fetch bridge and its memory slave.
// The master drives the request side; the slave drives data, ack, err and stall.
interface wb_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack;
  logic        err;
  logic        stall;

  modport master (
    output cyc, stb, we, sel, adr, dat_o,
    input  dat_i, ack, err, stall
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_o,
    output dat_i, ack, err, stall
  );
endinterface

// File: rtl/instr_fetch_wb_bridge.sv
// Ibex instruction-fetch (req/gnt/rvalid) to pipelined Wishbone read bridge with an
// outstanding-fetch counter and a watchdog that flushes orphaned fetches as errors.
module instr_fetch_wb_bridge #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned TIMEOUT         = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  wb_if.master        wb
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_ABORT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] timer_q, timer_d;

  logic        stb, cyc, gnt, resp, rvalid, err;
  logic [31:0] rdata;

  // Read-only, word-aligned fetches.
  assign wb.we    = 1'b0;
  assign wb.sel   = 4'hF;
  assign wb.dat_o = 32'h0;
  assign wb.adr   = instr_addr_i & 32'hFFFF_FFFC;

  assign wb.stb         = stb;
  assign wb.cyc         = cyc;
  assign instr_gnt_o    = gnt;
  assign instr_rvalid_o = rvalid;
  assign instr_err_o    = err;
  assign instr_rdata_o  = rdata;

  always_comb begin
    // NOTE: every signal gets a default first so no branch can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    stb     = 1'b0;
    cyc     = 1'b0;
    gnt     = 1'b0;
    resp    = 1'b0;
    rvalid  = 1'b0;
    err     = 1'b0;
    rdata   = wb.dat_i;

    unique case (state_q)
      ST_RUN: begin
        // Full is judged on the registered count only: a response frees a slot next cycle.
        stb    = instr_req_i && (cnt_q < CNT_MAX);
        gnt    = stb && !wb.stall;
        cyc    = stb || (cnt_q != '0);
        resp   = cyc && (wb.ack || wb.err) && (cnt_q != '0);
        rvalid = resp;
        err    = wb.err && !wb.ack;
        cnt_d  = cnt_q + CNT_W'(gnt) - CNT_W'(resp);

        if ((cnt_q == '0) || resp) begin
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end

        if ((cnt_q != '0) && !resp && (timer_q == TMR_LAST)) begin
          state_d = ST_ABORT;
          timer_d = '0;
        end
      end

      ST_ABORT: begin
        // Bus cycle dropped; drain one error response per orphaned fetch.
        timer_d = '0;
        rdata   = 32'h0;
        if (cnt_q != '0) begin
          rvalid = 1'b1;
          err    = 1'b1;
          cnt_d  = cnt_q - 1'b1;
        end
        if (cnt_d == '0) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (!rst_n) begin
      stb    = 1'b0;
      cyc    = 1'b0;
      gnt    = 1'b0;
      rvalid = 1'b0;
      err    = 1'b0;
    end
  end

  // NOTE: non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_wb_bridge.sv
// Directed bench for instr_fetch_wb_bridge against a behavioural pipelined memory slave
// with programmable ack latency (0 = never acks), stall and spurious ack/err injection.
module tb_instr_fetch_wb_bridge;

  localparam int unsigned MAX_OUT = 2;
  localparam int unsigned TMO     = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;
  logic        instr_err;

  logic        stall_r;
  logic        spur_ack;
  logic        spur_err;
  logic        slv_ack;
  logic [31:0] slv_dat;
  int          lat;

  int n_checks = 0;
  int n_errors = 0;

  wb_if wb_bus ();

  assign wb_bus.ack   = slv_ack | spur_ack;
  assign wb_bus.err   = spur_err;
  assign wb_bus.stall = stall_r;
  assign wb_bus.dat_i = slv_dat;

  instr_fetch_wb_bridge #(
    .MAX_OUTSTANDING (MAX_OUT),
    .TIMEOUT         (TMO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_req_i    (instr_req),
    .instr_addr_i   (instr_addr),
    .instr_gnt_o    (instr_gnt),
    .instr_rvalid_o (instr_rvalid),
    .instr_rdata_o  (instr_rdata),
    .instr_err_o    (instr_err),
    .wb             (wb_bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return 32'hC0DE_0000 ^ {16'h0, a[15:0]};
  endfunction

  // In-order slave: a beat accepted at edge n is acked in the cycle after edge n+lat-1.
  typedef struct {
    logic [31:0] addr;
    longint      due;
  } beat_t;

  beat_t  pend[$];
  longint cyc_n = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend.delete();
      slv_ack <= 1'b0;
      slv_dat <= 32'h0;
    end else begin
      beat_t b;
      cyc_n = cyc_n + 1;
      if (!wb_bus.cyc) begin
        pend.delete();
      end else if (wb_bus.stb && !wb_bus.stall) begin
        b.addr = wb_bus.adr;
        b.due  = (lat == 0) ? 64'sh7FFF_FFFF_FFFF : cyc_n + lat - 1;
        pend.push_back(b);
      end
      if (pend.size() > 0 && pend[0].due <= cyc_n) begin
        slv_ack <= 1'b1;
        slv_dat <= mem_rd(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        slv_ack <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n      = 1'b0;
    instr_req  = 1'b0;
    instr_addr = 32'h0;
    stall_r    = 1'b0;
    spur_ack   = 1'b0;
    spur_err   = 1'b0;
    lat        = 1;

    // Reset state
    sample();
    check("rst_gnt",    instr_gnt,    1'b0);
    check("rst_rvalid", instr_rvalid, 1'b0);
    check("rst_cyc",    wb_bus.cyc,   1'b0);
    check("rst_stb",    wb_bus.stb,   1'b0);
    check("rst_cnt",    dut.cnt_q,    0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Single fetch, 1-cycle ack
    instr_req = 1'b1; instr_addr = 32'h0000_0100;
    sample();
    check("t1_gnt", instr_gnt,  1'b1);
    check("t1_adr", wb_bus.adr, 32'h0000_0100);
    check("t1_we",  wb_bus.we,  1'b0);
    check("t1_sel", wb_bus.sel, 4'hF);
    check("t1_rv0", instr_rvalid, 1'b0);
    next_cycle();
    instr_req = 1'b0;
    sample();
    check("t1_rvalid", instr_rvalid, 1'b1);
    check("t1_rdata",  instr_rdata,  32'hDEAD_BEEF);
    check("t1_err",    instr_err,    1'b0);
    next_cycle();
    sample();
    check("t1_cnt", dut.cnt_q,  0);
    check("t1_cyc", wb_bus.cyc, 1'b0);

    // Back-to-back fetches, one per cycle
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      instr_req = 1'b1; instr_addr = 32'(4 * i);
      sample();
      check("t2_gnt", instr_gnt, 1'b1);
      check("t2_cnt", dut.cnt_q, (i > 0) ? 1 : 0);
      check("t2_rvalid", instr_rvalid, (i > 0) ? 1'b1 : 1'b0);
      if (i > 0) check("t2_rdata", instr_rdata, mem_rd(32'(4 * (i - 1))));
    end
    next_cycle();
    instr_req = 1'b0;
    sample();
    check("t2_rvalid_last", instr_rvalid, 1'b1);
    check("t2_rdata_last",  instr_rdata,  mem_rd(32'hC));
    check("t2_cyc_hold",    wb_bus.cyc,   1'b1);
    next_cycle();
    sample();
    check("t2_cyc_drop", wb_bus.cyc,   1'b0);
    check("t2_rv_drop",  instr_rvalid, 1'b0);

    // 5-cycle slave: pipeline fills at MAX_OUT, then waits for the first ack
    lat = 5;
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      instr_req  = (c < 6);
      instr_addr = 32'h200 + 32'(4 * ((c < 2) ? c : 2));
      sample();
      check("t3_cnt_le_max", (dut.cnt_q <= MAX_OUT), 1'b1);
      if (c < 2) check("t3_gnt", instr_gnt, 1'b1);
      if (c >= 2 && c <= 5) begin
        check("t3_full_gnt", instr_gnt,  1'b0);
        check("t3_full_stb", wb_bus.stb, 1'b0);
      end
      check("t3_rvalid", instr_rvalid, (c == 5 || c == 6) ? 1'b1 : 1'b0);
      if (c == 5) check("t3_rdata0", instr_rdata, mem_rd(32'h200));
      if (c == 6) check("t3_rdata1", instr_rdata, mem_rd(32'h204));
      if (c == 7) check("t3_cyc_end", wb_bus.cyc, 1'b0);
    end

    // Stall for 3 cycles
    lat = 1;
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      stall_r    = (c < 3);
      instr_req  = (c < 4);
      instr_addr = 32'h20;
      sample();
      if (c < 3) begin
        check("t4_stb", wb_bus.stb, 1'b1);
        check("t4_gnt", instr_gnt,  1'b0);
        check("t4_adr", wb_bus.adr, 32'h20);
      end
      if (c == 3) check("t4_gnt_after", instr_gnt, 1'b1);
      check("t4_rvalid", instr_rvalid, (c == 4) ? 1'b1 : 1'b0);
      if (c == 4) check("t4_rdata", instr_rdata, mem_rd(32'h20));
    end

    // Watchdog: slave never acks, two fetches orphaned
    lat = 0;
    for (int c = 0; c < 13; c++) begin
      next_cycle();
      if (c == 9) lat = 1;
      instr_req  = (c < 2) || (c >= 9 && c <= 11);
      instr_addr = (c < 2) ? 32'h40 + 32'(4 * c) : 32'h80;
      sample();
      if (c < 2) check("t5_gnt", instr_gnt, 1'b1);
      if (c >= 2 && c <= 8) begin
        check("t5_cyc_wait", wb_bus.cyc,   1'b1);
        check("t5_rv_wait",  instr_rvalid, 1'b0);
      end
      if (c == 9 || c == 10) begin
        check("t5_abort_cyc",   wb_bus.cyc,   1'b0);
        check("t5_abort_stb",   wb_bus.stb,   1'b0);
        check("t5_abort_gnt",   instr_gnt,    1'b0);
        check("t5_abort_rv",    instr_rvalid, 1'b1);
        check("t5_abort_err",   instr_err,    1'b1);
        check("t5_abort_rdata", instr_rdata,  32'h0);
        check("t5_abort_cnt",   dut.cnt_q,    (c == 9) ? 2 : 1);
      end
      if (c == 11) begin
        check("t5_resume_gnt", instr_gnt,    1'b1);
        check("t5_resume_rv",  instr_rvalid, 1'b0);
        check("t5_resume_cnt", dut.cnt_q,    0);
      end
      if (c == 12) begin
        check("t5_new_rv",    instr_rvalid, 1'b1);
        check("t5_new_err",   instr_err,    1'b0);
        check("t5_new_rdata", instr_rdata,  mem_rd(32'h80));
      end
    end

    // Spurious ack and err with nothing outstanding
    next_cycle();
    spur_ack = 1'b1;
    sample();
    check("t6_spur_ack_rv", instr_rvalid, 1'b0);
    next_cycle();
    spur_ack = 1'b0; spur_err = 1'b1;
    sample();
    check("t6_spur_err_rv", instr_rvalid, 1'b0);
    check("t6_spur_cnt0",   dut.cnt_q,    0);
    next_cycle();
    spur_err = 1'b0;
    sample();
    check("t6_spur_cnt1", dut.cnt_q, 0);

    // Reset with two fetches in flight
    lat = 0;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      instr_req = 1'b1; instr_addr = 32'h300 + 32'(4 * c);
      sample();
      check("t7_gnt", instr_gnt, (c < 2) ? 1'b1 : 1'b0);
    end
    check("t7_cnt_full", dut.cnt_q, 2);
    next_cycle();
    rst_n = 1'b0;
    sample();
    check("t7_rst_cyc", wb_bus.cyc,   1'b0);
    check("t7_rst_stb", wb_bus.stb,   1'b0);
    check("t7_rst_gnt", instr_gnt,    1'b0);
    check("t7_rst_rv",  instr_rvalid, 1'b0);
    check("t7_rst_cnt", dut.cnt_q,    0);
    next_cycle();
    rst_n = 1'b1; instr_req = 1'b0; lat = 1;
    sample();
    check("t7_post_cnt", dut.cnt_q,  0);
    check("t7_post_cyc", wb_bus.cyc, 1'b0);
    next_cycle();
    instr_req = 1'b1; instr_addr = 32'h100;
    sample();
    check("t7_post_gnt", instr_gnt, 1'b1);
    next_cycle();
    instr_req = 1'b0;
    sample();
    check("t7_post_rv",    instr_rvalid, 1'b1);
    check("t7_post_rdata", instr_rdata,  32'hDEAD_BEEF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
